stb_wr_responder: RTL and testbench
===================================

STB_WR_RESPONDER -- requirements
Module: stb_wr_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter BYTE_SEL_WIDTH, default 4, byte-lane mask width (DATA_WIDTH/8).
REQ-004 SHALL have parameter NUM_LINES, default 16, power-of-two line count; each line holds one word.
REQ-005 SHALL have the port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have the port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have the ports stb2dcache_addr, stb2dcache_wdata and stb2dcache_sel_byte, inputs, ADDR_WIDTH/DATA_WIDTH/BYTE_SEL_WIDTH, the store-buffer write.
REQ-008 SHALL have the ports stb2dcache_req, stb2dcache_w_en and dmem_sel_i, inputs, 1 each, request qualifiers.
REQ-009 SHALL have the port dcache2stb_ack, output, 1, write-complete pulse to the store buffer.
REQ-010 SHALL have the ports dcache2mem_addr, dcache2mem_wdata and dcache2mem_sel_byte, outputs, ADDR_WIDTH/DATA_WIDTH/BYTE_SEL_WIDTH, write-through to memory.
REQ-011 SHALL have the ports dcache2mem_req and dcache2mem_w_en, outputs, 1 each; the port mem2dcache_ack, input, 1.
REQ-012 SHALL have the port dcache_flush_i, input, 1, invalidate-all request; the port dcache_busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL accept a write only in IDLE when stb2dcache_req && stb2dcache_w_en && dmem_sel_i are all 1, latching addr, wdata and sel_byte that cycle.
REQ-014 SHALL implement states IDLE -> LOOKUP -> MEM_WR -> ACK -> IDLE, one transition per cycle except MEM_WR.
REQ-015 SHALL in LOOKUP derive index = addr[log2(NUM_LINES)+1:2] and tag = addr[ADDR_WIDTH-1:log2(NUM_LINES)+2]; addr[1:0] ignored; hit = valid[index] && tag match.
REQ-016 SHALL on hit merge only the bytes whose sel_byte bit is 1 into the line at the LOOKUP->MEM_WR edge; unselected bytes unchanged.
REQ-017 SHALL on miss leave the array untouched (allocation: see Configuration).
REQ-018 SHALL assert dcache2mem_req and dcache2mem_w_en, holding latched addr/wdata/sel_byte stable, for every cycle in MEM_WR, hit or miss (write-through).
REQ-019 SHALL leave MEM_WR for ACK on the cycle mem2dcache_ack is sampled 1; dcache2mem_req deasserts in ACK.
REQ-020 SHALL drive dcache2stb_ack high for exactly one cycle (state ACK), never in any other state.
REQ-021 SHALL give minimum accept-to-ack latency of 3 cycles with a zero-wait memory ack.
REQ-022 SHALL ignore stb2dcache_req while not IDLE; requests are neither queued nor dropped silently (the initiator holds req until ack).
REQ-023 SHALL with sel_byte = 0 still complete the full handshake, with no array change.
REQ-024 SHALL on dcache_flush_i in IDLE clear all valid bits at that edge, with flush priority over a same-cycle write (write is accepted next cycle).
REQ-025 SHALL hold a flush asserted while busy pending, executing it on the first IDLE cycle.

Reset
REQ-026 SHALL on rst, regardless of state or in-flight memory write, force IDLE, clear all valid bits and pending flush, and drive dcache2stb_ack, dcache2mem_req, dcache2mem_w_en, dcache_busy_o to 0 and dcache2mem_addr/wdata/sel_byte to 0.
REQ-027 SHALL leave data array contents unreset.

Configuration
REQ-028 SHALL with DCACHE_WR_ALLOC_EN defined make a miss with sel_byte all-ones write the word, set valid and store the tag at the LOOKUP->MEM_WR edge.
REQ-029 SHALL without DCACHE_WR_ALLOC_EN never allocate on a miss; partial-mask misses never allocate in either build.

Structure
REQ-030 SHALL place the state enum (IDLE, LOOKUP, MEM_WR, ACK) and the index/tag width localparams in the shared cache package.
REQ-031 SHALL isolate the tag/valid/data array with byte-enable write in sub-module stb_wr_array.

Verification
REQ-032 SHALL cover the hit write: preload 0x1000 = 0xAABBCCDD valid; write 0x1000, wdata 0x11223344, sel 0b0101 -> line 0xAA22CC44, mem write sel 0b0101, ack 3 cycles after accept.
REQ-033 SHALL cover the miss write: write 0x2004, sel 0xF, memory ack after 5 waits -> dcache2mem_req held 5+1 cycles, stable fields, one ack pulse; line valid only with DCACHE_WR_ALLOC_EN.
REQ-034 SHALL cover a request with dmem_sel_i = 0 or w_en = 0 -> no state change, no mem req, no ack.
REQ-035 SHALL cover flush during MEM_WR -> write completes, then all valid bits clear on the first IDLE cycle, and a follow-up write to 0x1000 misses.
REQ-036 SHALL cover rst asserted mid-MEM_WR -> dcache2mem_req drops asynchronously, no ack, IDLE after release.

Source files
------------

// File: rtl/stb_wr_responder_pkg.sv
// Shared definitions for the store-buffer write responder: FSM state
// encoding and helpers that derive the index/tag split of a byte address.
package stb_wr_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MEM_WR = 2'd2,
        ACK    = 2'd3
    } state_e;

    // Index bits needed to select one of num_lines words.
    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag bits left above the index and the two byte-offset bits.
    function automatic int tag_width(input int addr_width, input int num_lines);
        return addr_width - $clog2(num_lines) - 2;
    endfunction

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_NUM_LINES  = 16;
    localparam int DEF_INDEX_W    = index_width(DEF_NUM_LINES);
    localparam int DEF_TAG_W      = tag_width(DEF_ADDR_WIDTH, DEF_NUM_LINES);

endpackage

// File: rtl/stb_wr_responder_array.sv
// Direct-mapped tag/valid/data store with per-byte write enables.
// Valid bits reset and flush-clear; tag and data contents are never reset.
module stb_wr_array #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int NUM_LINES      = 16,
    parameter int INDEX_W        = 4,
    parameter int TAG_W          = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INDEX_W-1:0]        i_index,
    input  logic [TAG_W-1:0]          i_tag,
    input  logic                      i_wr_en,
    input  logic [BYTE_SEL_WIDTH-1:0] i_wr_sel,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_set_valid,
    input  logic                      i_flush,
    output logic                      o_hit
);

    logic [DATA_WIDTH-1:0] r_data  [NUM_LINES];
    logic [TAG_W-1:0]      r_tag   [NUM_LINES];
    logic [NUM_LINES-1:0]  r_valid;

    assign o_hit = r_valid[i_index] && (r_tag[i_index] == i_tag);

    // Byte-lane merge of write data into the addressed line.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
            if (i_wr_en && i_wr_sel[b]) begin
                r_data[i_index][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
        end
    end

    // Tag capture when a line is (re)allocated.
    always_ff @(posedge clk) begin
        if (i_set_valid) begin
            r_tag[i_index] <= i_tag;
        end
    end

    // Valid bits: cleared by reset or flush, set on allocation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= {NUM_LINES{1'b0}};
        end else if (i_flush) begin
            r_valid <= {NUM_LINES{1'b0}};
        end else if (i_set_valid) begin
            r_valid[i_index] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: rtl/stb_wr_responder.sv
// Store-buffer write responder: accepts one store, updates the cache line on
// a hit, writes the store through to memory and returns a one-cycle ack.
// Optional feature macro DCACHE_WR_ALLOC_EN: a full-mask miss allocates the
// line; without it (default) misses never touch the array.
module stb_wr_responder
    import stb_wr_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = 4,
    parameter int NUM_LINES      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
    input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
    input  logic                      stb2dcache_req,
    input  logic                      stb2dcache_w_en,
    input  logic                      dmem_sel_i,
    output logic                      dcache2stb_ack,
    output logic [ADDR_WIDTH-1:0]     dcache2mem_addr,
    output logic [DATA_WIDTH-1:0]     dcache2mem_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte,
    output logic                      dcache2mem_req,
    output logic                      dcache2mem_w_en,
    input  logic                      mem2dcache_ack,
    input  logic                      dcache_flush_i,
    output logic                      dcache_busy_o
);

    localparam int INDEX_W = index_width(NUM_LINES);
    localparam int TAG_W   = tag_width(ADDR_WIDTH, NUM_LINES);

    state_e                    r_state;
    state_e                    w_next_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [BYTE_SEL_WIDTH-1:0] r_sel;
    logic                      r_flush_pend;
    logic                      r_mem_req;
    logic                      r_mem_w_en;
    logic                      r_stb_ack;
    logic                      r_busy;

    logic                      w_accept;
    logic                      w_do_flush;
    logic                      w_hit;
    logic                      w_alloc;
    logic                      w_arr_wr_en;
    logic                      w_arr_set_valid;
    logic [INDEX_W-1:0]        w_index;
    logic [TAG_W-1:0]          w_tag;

    // Byte offset bits [1:0] play no part in the lookup.
    assign w_index = r_addr[INDEX_W+1:2];
    assign w_tag   = r_addr[ADDR_WIDTH-1:INDEX_W+2];

`ifdef DCACHE_WR_ALLOC_EN
    // Only a full-word store carries enough data to fill a fresh line.
    assign w_alloc = !w_hit && (&r_sel);
`else
    assign w_alloc = 1'b0;
`endif

    // Next-state decode; a flush in IDLE wins over a same-cycle store.
    always_comb begin
        w_next_state    = r_state;
        w_accept        = 1'b0;
        w_do_flush      = 1'b0;
        w_arr_wr_en     = 1'b0;
        w_arr_set_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_flush_pend || dcache_flush_i) begin
                    w_do_flush = 1'b1;
                end else if (stb2dcache_req && stb2dcache_w_en && dmem_sel_i) begin
                    w_accept     = 1'b1;
                    w_next_state = LOOKUP;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOOKUP: begin
                w_arr_wr_en     = w_hit || w_alloc;
                w_arr_set_valid = w_alloc;
                w_next_state    = MEM_WR;
            end
            MEM_WR: begin
                if (mem2dcache_ack) begin
                    w_next_state = ACK;
                end else begin
                    w_next_state = MEM_WR;
                end
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the store fields at acceptance and hold them for the whole write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
            r_sel   <= {BYTE_SEL_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_addr  <= stb2dcache_addr;
            r_wdata <= stb2dcache_wdata;
            r_sel   <= stb2dcache_sel_byte;
        end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
            r_sel   <= r_sel;
        end
    end

    // Remember a flush seen while busy until the next IDLE cycle executes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (w_do_flush) begin
            r_flush_pend <= 1'b0;
        end else if (dcache_flush_i && (r_state != IDLE)) begin
            r_flush_pend <= 1'b1;
        end else begin
            r_flush_pend <= r_flush_pend;
        end
    end

    // Registered handshake outputs decoded from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_stb_ack  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_mem_req  <= (w_next_state == MEM_WR);
            r_mem_w_en <= (w_next_state == MEM_WR);
            r_stb_ack  <= (w_next_state == ACK);
            r_busy     <= (w_next_state != IDLE);
        end
    end

    stb_wr_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
        .NUM_LINES      (NUM_LINES),
        .INDEX_W        (INDEX_W),
        .TAG_W          (TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .i_tag       (w_tag),
        .i_wr_en     (w_arr_wr_en),
        .i_wr_sel    (r_sel),
        .i_wr_data   (r_wdata),
        .i_set_valid (w_arr_set_valid),
        .i_flush     (w_do_flush),
        .o_hit       (w_hit)
    );

    assign dcache2stb_ack      = r_stb_ack;
    assign dcache2mem_addr     = r_addr;
    assign dcache2mem_wdata    = r_wdata;
    assign dcache2mem_sel_byte = r_sel;
    assign dcache2mem_req      = r_mem_req;
    assign dcache2mem_w_en     = r_mem_w_en;
    assign dcache_busy_o       = r_busy;

endmodule

// File: tb/tb_stb_wr_responder.sv
// Scoreboard bench for stb_wr_responder: the driver queues the expected
// memory write and ack cycle, a negedge monitor pops and compares them.
module tb_stb_wr_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stb_addr;
    logic [31:0] stb_wdata;
    logic [3:0]  stb_sel;
    logic        stb_req;
    logic        stb_w_en;
    logic        dmem_sel;
    logic        stb_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        mem_req;
    logic        mem_w_en;
    logic        mem_ack = 1'b0;
    logic        flush;
    logic        busy;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } mw_t;

    mw_t exp_mem_q [$];
    int  exp_ack_q [$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  mem_waits = 0;
    int  mem_cnt   = 0;
    int  run_len   = 0;
    int  last_run  = 0;
    mw_t cur;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    stb_wr_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .stb2dcache_addr     (stb_addr),
        .stb2dcache_wdata    (stb_wdata),
        .stb2dcache_sel_byte (stb_sel),
        .stb2dcache_req      (stb_req),
        .stb2dcache_w_en     (stb_w_en),
        .dmem_sel_i          (dmem_sel),
        .dcache2stb_ack      (stb_ack),
        .dcache2mem_addr     (mem_addr),
        .dcache2mem_wdata    (mem_wdata),
        .dcache2mem_sel_byte (mem_sel),
        .dcache2mem_req      (mem_req),
        .dcache2mem_w_en     (mem_w_en),
        .mem2dcache_ack      (mem_ack),
        .dcache_flush_i      (flush),
        .dcache_busy_o       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: acknowledges after mem_waits wait cycles of a request.
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack = (mem_cnt == mem_waits);
            mem_cnt++;
        end else begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end
    end

    // Monitor: compares every presented memory write and ack with the queues.
    always @(negedge clk) begin
        if (mem_req) begin
            if (!prev_req) begin
                run_len = 0;
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected none", mem_addr);
                    cur = '{a: mem_addr, d: mem_wdata, s: mem_sel};
                end else begin
                    cur = exp_mem_q.pop_front();
                end
            end
            run_len++;
            chk("mem_addr", mem_addr, cur.a);
            chk("mem_wdata", mem_wdata, cur.d);
            chk("mem_sel", mem_sel, cur.s);
            chk("mem_w_en", mem_w_en, 1);
        end else if (prev_req) begin
            last_run = run_len;
        end
        if (stb_ack) begin
            if (prev_ack) begin
                checks++;
                failures++;
                $display("FAIL ack_width: got ack high 2 cycles expected 1");
            end
            if (exp_ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                chk("ack_cycle", cyc, exp_ack_q.pop_front());
            end
        end
        prev_req = mem_req;
        prev_ack = stb_ack;
    end

    // One store: expected ack cycle = issue cycle + 3 + waits + extra.
    // flush_at >= 0 pulses flush for one cycle that many cycles after issue.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int waits, input int flush_at, input int extra);
        logic done;
        @(posedge clk);
        #1;
        mem_waits = waits;
        stb_addr  = a;
        stb_wdata = d;
        stb_sel   = s;
        stb_req   = 1'b1;
        stb_w_en  = 1'b1;
        dmem_sel  = 1'b1;
        exp_mem_q.push_back('{a: a, d: d, s: s});
        exp_ack_q.push_back(cyc + 3 + waits + extra);
        if (flush_at == 0) flush = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (i == flush_at + 1) flush = 1'b0;
            if (i == flush_at && flush_at > 0) flush = 1'b1;
            if (stb_ack) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: got no ack expected one for addr %0h", a);
        end
        @(posedge clk);
        #1;
        stb_req  = 1'b0;
        stb_w_en = 1'b0;
        dmem_sel = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stb_addr = 32'h0; stb_wdata = 32'h0; stb_sel = 4'h0;
        stb_req = 1'b0; stb_w_en = 1'b0; dmem_sel = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", stb_ack, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_w_en", mem_w_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_valid", dut.u_array.r_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload line 0 with address 0x1000 (index 0, tag 0x40).
        @(posedge clk);
        #1;
        dut.u_array.r_data[0] = 32'hAABBCCDD;
        dut.u_array.r_tag[0]  = 26'h40;
        dut.u_array.r_valid[0] = 1'b1;

        // Hit write with partial mask, zero-wait memory.
        wr(32'h1000, 32'h11223344, 4'b0101, 0, -1, 0);
        chk("hit_merge", dut.u_array.r_data[0], 32'hAA22CC44);
        chk("hit_valid", dut.u_array.r_valid[0], 1);

        // Miss write with full mask and 5 memory wait cycles.
        wr(32'h2004, 32'h0BADBEEF, 4'hF, 5, -1, 0);
        chk("miss_req_len", last_run, 6);
`ifdef DCACHE_WR_ALLOC_EN
        chk("miss_alloc_valid", dut.u_array.r_valid[1], 1);
        chk("miss_alloc_data", dut.u_array.r_data[1], 32'h0BADBEEF);
`else
        chk("miss_alloc_valid", dut.u_array.r_valid[1], 0);
`endif
        chk("miss_line0_kept", dut.u_array.r_data[0], 32'hAA22CC44);

        // Empty byte mask: full handshake, line unchanged.
        wr(32'h1000, 32'hFFFFFFFF, 4'h0, 1, -1, 0);
        chk("sel0_line", dut.u_array.r_data[0], 32'hAA22CC44);
        chk("sel0_valid", dut.u_array.r_valid[0], 1);

        // Unqualified requests are ignored.
        @(posedge clk);
        #1;
        stb_addr = 32'h1000; stb_wdata = 32'h0; stb_sel = 4'hF;
        stb_req = 1'b1; stb_w_en = 1'b1; dmem_sel = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("nosel_busy", busy, 0);
            chk("nosel_mem_req", mem_req, 0);
        end
        dmem_sel = 1'b1; stb_w_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("nowen_busy", busy, 0);
            chk("nowen_mem_req", mem_req, 0);
        end
        stb_req = 1'b0; dmem_sel = 1'b0;
        chk("unqual_line", dut.u_array.r_data[0], 32'hAA22CC44);

        // Flush during MEM_WR: write completes, flush runs on the first IDLE edge.
        wr(32'h1000, 32'h55667788, 4'hF, 3, 2, 0);
        chk("flush_deferred", dut.u_array.r_valid[0], 1);
        chk("flush_hit_data", dut.u_array.r_data[0], 32'h55667788);
        @(posedge clk);
        #1;
        chk("flush_cleared", dut.u_array.r_valid, 0);

        // Follow-up write to 0x1000 now misses.
        wr(32'h1000, 32'h01020304, 4'hF, 0, -1, 0);
`ifdef DCACHE_WR_ALLOC_EN
        chk("post_flush_data", dut.u_array.r_data[0], 32'h01020304);
        chk("post_flush_valid", dut.u_array.r_valid[0], 1);
`else
        chk("post_flush_data", dut.u_array.r_data[0], 32'h55667788);
        chk("post_flush_valid", dut.u_array.r_valid[0], 0);
`endif

        // Flush and store in the same IDLE cycle: store accepted one cycle later.
        wr(32'h2004, 32'hCAFEF00D, 4'h3, 1, 0, 1);
        chk("same_cycle_flush", dut.u_array.r_valid, 0);

        // Reset in the middle of a memory write.
        @(posedge clk);
        #1;
        dut.u_array.r_valid[3] = 1'b1;
        mem_waits = 20;
        stb_addr = 32'h300C; stb_wdata = 32'h12345678; stb_sel = 4'hF;
        stb_req = 1'b1; stb_w_en = 1'b1; dmem_sel = 1'b1;
        exp_mem_q.push_back('{a: 32'h300C, d: 32'h12345678, s: 4'hF});
        repeat (4) @(negedge clk);
        chk("pre_rst_mem_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_mem_req", mem_req, 0);
        chk("rst_async_ack", stb_ack, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_addr", mem_addr, 0);
        chk("rst_async_valid", dut.u_array.r_valid, 0);
        stb_req = 1'b0; stb_w_en = 1'b0; dmem_sel = 1'b0;
        exp_ack_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_mem_req", mem_req, 0);
        end

        chk("mem_q_empty", exp_mem_q.size(), 0);
        chk("ack_q_empty", exp_ack_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
